// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: "breathing" duty source for a runtime-duty PWM.
//   The duty ramps up in STEP increments, holds at full duty, ramps down, holds
//   at zero, and then repeats. Every duty change happens on a frame-wrap edge, so
//   the new value is valid in the cycle where period_start is high.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   en           in   run enable; while low, all state is frozen
//   duty         out  current duty in clock cycles, 0..PERIOD (registered)
//   period_start out  one-cycle strobe on the first cycle of a period (registered)
//   phase        out  0=RISE 1=HOLD_HI 2=FALL 3=HOLD_LO
module pwm_duty_ramp #(
  parameter int PERIOD           = 1000,
  parameter int STEP             = 10,
  parameter int PERIODS_PER_STEP = 100,
  parameter int HOLD_PERIODS     = 50,
  parameter int DUTY_W           = $clog2(PERIOD+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DUTY_W-1:0] duty,
  output logic              period_start,
  output logic [1:0]        phase
);

  localparam int CNT_W = (PERIOD > 1)           ? $clog2(PERIOD)           : 1;
  localparam int SC_W  = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam int HC_W  = (HOLD_PERIODS > 1)     ? $clog2(HOLD_PERIODS)     : 1;
  localparam int DW1   = DUTY_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(PERIODS_PER_STEP - 1);
  localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(HOLD_PERIODS - 1);
  localparam logic [DW1-1:0]    STEP_X   = DW1'(STEP);
  localparam logic [DW1-1:0]    PERIOD_X = DW1'(PERIOD);
  localparam logic [DUTY_W-1:0] STEP_D   = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] PERIOD_D = DUTY_W'(PERIOD);

  // Reject illegal parameter sets at elaboration.
  generate
    if (PERIOD < 1) begin : g_bad_period
      $error("pwm_duty_ramp: PERIOD must be >= 1");
    end
    if (STEP < 1 || STEP > PERIOD) begin : g_bad_step
      $error("pwm_duty_ramp: STEP must be in 1..PERIOD");
    end
    if (PERIODS_PER_STEP < 1) begin : g_bad_pps
      $error("pwm_duty_ramp: PERIODS_PER_STEP must be >= 1");
    end
    if (HOLD_PERIODS < 1) begin : g_bad_hold
      $error("pwm_duty_ramp: HOLD_PERIODS must be >= 1");
    end
    if (DUTY_W != $clog2(PERIOD+1)) begin : g_bad_dw
      $error("pwm_duty_ramp: DUTY_W is derived and must not be overridden");
    end
  endgenerate

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SC_W-1:0]   step_cnt_q, step_cnt_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              ps_q, ps_d;

  logic              wrap;
  logic [DW1-1:0]    sum_up;
  logic [DUTY_W-1:0] up_sat, dn_sat;

  // The wrap edge is the only moment anything other than cnt may change.
  assign wrap = en && (cnt_q == CNT_LAST);

  // The sum is one bit wider so it cannot overflow before it is clamped to PERIOD.
  assign sum_up = {1'b0, duty_q} + STEP_X;
  assign up_sat = (sum_up > PERIOD_X) ? PERIOD_D : sum_up[DUTY_W-1:0];
  assign dn_sat = (duty_q >= STEP_D) ? (duty_q - STEP_D) : '0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= RISE;
      cnt_q      <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      duty_q     <= '0;
      ps_q       <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      duty_q     <= duty_d;
      ps_q       <= ps_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d    = phase_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    duty_d     = duty_q;
    ps_d       = wrap;
    cnt_d      = cnt_q;
    if (wrap)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);

    if (wrap) begin
      unique case (phase_q)
        RISE: begin
          if (step_cnt_q == SC_LAST) begin
            duty_d     = up_sat;
            step_cnt_d = '0;
            if (up_sat == PERIOD_D) begin
              phase_d    = HOLD_HI;
              hold_cnt_d = '0;
            end
          end else begin
            step_cnt_d = step_cnt_q + SC_W'(1);
          end
        end
        FALL: begin
          if (step_cnt_q == SC_LAST) begin
            duty_d     = dn_sat;
            step_cnt_d = '0;
            if (dn_sat == '0) begin
              phase_d    = HOLD_LO;
              hold_cnt_d = '0;
            end
          end else begin
            step_cnt_d = step_cnt_q + SC_W'(1);
          end
        end
        HOLD_HI, HOLD_LO: begin
          if (hold_cnt_q == HC_LAST) begin
            phase_d    = (phase_q == HOLD_HI) ? FALL : RISE;
            hold_cnt_d = '0;
            step_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end
        default: phase_d = RISE;
      endcase
    end
  end

  // Output logic: every output comes straight from a register.
  always_comb begin
    duty         = duty_q;
    period_start = ps_q;
    phase        = phase_q;
  end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Upstream duty-cycle source for the PWM stage: a "breathing" generator that ramps duty up, holds, ramps down, holds, and repeats.
- Runs its own PERIOD-cycle frame counter, identical to the PWM's, and emits a one-cycle period_start strobe.
- The downstream runtime-duty PWM loads duty only on period_start, so no glitched or partial periods reach the LEDs.

Parameters:
- PERIOD, 1000, clock cycles per PWM period; must equal the downstream PWM period.
- STEP, 10, duty change per ramp step in clock cycles; 1 <= STEP <= PERIOD.
- PERIODS_PER_STEP, 100, PWM periods between ramp steps; >= 1.
- HOLD_PERIODS, 50, PWM periods spent at full and at zero duty; >= 1.
- DUTY_W, $clog2(PERIOD+1), width of duty; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low freezes all state.
- duty  out  DUTY_W  current duty in clock cycles, range 0..PERIOD; registered.
- period_start  out  1  one-cycle strobe marking the first cycle of a PWM period; registered.
- phase  out  2  current state: 0=RISE, 1=HOLD_HI, 2=FALL, 3=HOLD_LO.

Behaviour:
- Reset (async assert, immediate clear):
  - cnt=0, step_cnt=0, hold_cnt=0, duty=0, phase=RISE, period_start=0.
  - Takes effect mid-period or mid-ramp with no completion of the pending step.
  - Release is synchronous to clk.
- Frame counter cnt:
  - Counts 0..PERIOD-1 on each clk with en=1.
  - Wrap edge: en=1 and cnt==PERIOD-1. At that edge cnt<=0 and period_start<=1. At all other edges period_start<=0.
  - No strobe on reset release; the first period_start appears after PERIOD enabled cycles.
- en=0: cnt, step_cnt, hold_cnt, duty and phase hold; period_start<=0. When en returns, counting resumes from the held cnt, with no skipped or duplicated wrap.
- Step counter: step_cnt counts wrap edges in RISE/FALL. Step event = wrap edge with step_cnt==PERIODS_PER_STEP-1. On a step event step_cnt<=0.
- Duty updates only on wrap edges, so the new duty is valid in the same cycle period_start is high.
- Arithmetic is done at DUTY_W+1 bits and saturates; duty never exceeds PERIOD and never underflows.
- State machine:
  - RISE: on step event, duty<=min(duty+STEP, PERIOD). If the result ==PERIOD, go to HOLD_HI in the same edge.
  - HOLD_HI: hold_cnt counts wraps. On a wrap with hold_cnt==HOLD_PERIODS-1, go to FALL. duty is unchanged.
  - FALL: on step event, duty<=max(duty-STEP, 0). If the result ==0, go to HOLD_LO in the same edge.
  - HOLD_LO: as HOLD_HI, then go to RISE.
  - step_cnt and hold_cnt clear on every state transition.
- STEP not dividing PERIOD: the last step saturates, e.g. 9 -> 10 with STEP=3, PERIOD=10.
- STEP==PERIOD: single-step ramps, 0 -> PERIOD -> 0.
- Illegal parameter values are rejected by elaboration-time assertion.
- Latency: duty change is visible at the output on the cycle after the wrap edge, together with period_start.

Test Plan:
Bench parameters: PERIOD=10, STEP=3, PERIODS_PER_STEP=2, HOLD_PERIODS=3, en=1. t = enabled clock edges after reset release.
1. Rise: period_start pulses after edges 10, 20, 30, ...; duty 0 -> 3 @20 -> 6 @40 -> 9 @60 -> 10 @80 (saturated); phase=1 after edge 80.
2. Hold/fall: phase=2 after edge 110; duty 7 @130, 4 @150, 1 @170, 0 @190 (floor), phase=3; phase=0 after edge 220; next rise to 3 @240.
3. Enable gating: drop en for 7 cycles at cnt=4 during RISE -> duty, cnt, phase frozen and period_start=0 throughout; the next wrap occurs 6 enabled cycles after resume; the ramp schedule shifts by exactly 7 cycles.
4. Async reset mid-FALL (duty=4): assert rst between edges -> outputs read 0/0/RISE before the next clk edge; after release, case 1 repeats exactly.
5. Re-run with STEP=PERIOD=10 -> duty 0 -> 10 @20, phase 1; 0 @70 after hold; check duty never exceeds 10 and never wraps negative across 3 full cycles.
6. Defaults (PERIOD=1000) long run -> exactly one period_start per 1000 enabled cycles; duty changes only in period_start cycles; full breathing cycle = 2*100*100+2*50 = 20100 periods.
